// File: rtl/approx_mul_pipe_pkg.sv
// Shared types and constants for the Mitchell approximate multiplier.
package approx_mul_pipe_pkg;

  // Operation selector carried with every transaction.
  typedef enum logic [1:0] {
    MUL_APPROX_U = 2'd0,
    MUL_APPROX_S = 2'd1,
    MUL_EXACT    = 2'd2
  } approx_mode_t;

  // Linear error correction is NUM / 2^SHIFT of one unit of the fraction.
  localparam int MITCHELL_CORR_NUM   = 5;
  localparam int MITCHELL_CORR_SHIFT = 6;

  // Correction term expressed in a fraction with frac_bits bits.
  function automatic int mitchell_corr(input int frac_bits);
    return MITCHELL_CORR_NUM << (frac_bits - MITCHELL_CORR_SHIFT);
  endfunction

endpackage

// File: rtl/approx_mul_pipe_leading_one_detector.sv
// Leading-one position of an unsigned value; index is 0 when the value is 0.
module leading_one_detector
  import approx_mul_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]         value,
  output logic [$clog2(WIDTH)-1:0] index,
  output logic                     is_zero
);

  localparam int IW = $clog2(WIDTH);

  // Scan from LSB to MSB so the highest set bit is the one that sticks.
  always_comb begin
    index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      index = value[i] ? IW'(i) : index;
    end
  end

  assign is_zero = (value == '0);

endmodule

// File: rtl/approx_mul_pipe.sv
// Three-stage Mitchell-logarithm multiplier with linear correction,
// signed/unsigned approximate modes and an exact pass-through mode.
module approx_mul_pipe
  import approx_mul_pipe_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  approx_mode_t         in_mode,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam int F  = WIDTH - 1;          // fraction bits
  localparam int IW = $clog2(WIDTH);      // leading-one index width
  localparam int KW = $clog2(2 * WIDTH);  // summed exponent width
  localparam int PW = 2 * WIDTH;          // product width
  localparam int XW = 3 * WIDTH + 1;      // scaled mantissa width

  localparam logic [F:0]      CORR_FULL = (F + 1)'(mitchell_corr(F));
  localparam logic [F:0]      CORR_HALF = CORR_FULL >> 1;
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH - 1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]   ONE_P     = {{(PW - 1){1'b0}}, 1'b1};
  localparam logic [PW+1:0]   POS_LIM   = {3'b000, {(PW - 1){1'b1}}};
  localparam logic [PW+1:0]   NEG_LIM   = {3'b001, {(PW - 1){1'b0}}};

  // Whole pipeline advances together; a held output freezes every stage.
  logic adv_s;
  assign adv_s    = !out_valid || out_ready;
  assign in_ready = adv_s;

  // ---------------- S1: sign / normalise ----------------
  logic             signed_mode_s;
  logic [WIDTH-1:0] mag_a_s, mag_b_s;
  logic [IW-1:0]    k_a_s, k_b_s;
  logic             zero_a_s, zero_b_s;
  logic [F-1:0]     x_a_s, x_b_s;
  logic             sign_s;
  logic [PW-1:0]    exact_s;

  leading_one_detector #(.WIDTH(WIDTH)) u_lod_a (
    .value   (mag_a_s),
    .index   (k_a_s),
    .is_zero (zero_a_s)
  );

  leading_one_detector #(.WIDTH(WIDTH)) u_lod_b (
    .value   (mag_b_s),
    .index   (k_b_s),
    .is_zero (zero_b_s)
  );

  // Magnitudes, sign, normalised fractions and the exact product.
  always_comb begin
    signed_mode_s = (in_mode == MUL_APPROX_S);
    if (signed_mode_s && in_a[WIDTH-1]) begin
      mag_a_s = ~in_a + ONE_W;
    end else begin
      mag_a_s = in_a;
    end
    if (signed_mode_s && in_b[WIDTH-1]) begin
      mag_b_s = ~in_b + ONE_W;
    end else begin
      mag_b_s = in_b;
    end
    sign_s  = signed_mode_s & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
    // Shifting the leading one to bit F and truncating drops it.
    x_a_s   = F'(mag_a_s << (IW'(F) - k_a_s));
    x_b_s   = F'(mag_b_s << (IW'(F) - k_b_s));
    exact_s = PW'(in_a) * PW'(in_b);
  end

  logic             s1_valid_r;
  approx_mode_t     s1_mode_r;
  logic [TAG_WIDTH-1:0] s1_tag_r;
  logic             s1_sign_r, s1_zero_r;
  logic [IW-1:0]    s1_ka_r, s1_kb_r;
  logic [F-1:0]     s1_xa_r, s1_xb_r;
  logic [PW-1:0]    s1_exact_r;

  // S1 register: capture the normalised operands when the pipe advances.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      s1_mode_r  <= MUL_APPROX_U;
      s1_tag_r   <= '0;
      s1_sign_r  <= 1'b0;
      s1_zero_r  <= 1'b0;
      s1_ka_r    <= '0;
      s1_kb_r    <= '0;
      s1_xa_r    <= '0;
      s1_xb_r    <= '0;
      s1_exact_r <= '0;
    end else if (adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_mode_r  <= in_mode;
        s1_tag_r   <= in_tag;
        s1_sign_r  <= sign_s;
        s1_zero_r  <= zero_a_s | zero_b_s;
        s1_ka_r    <= k_a_s;
        s1_kb_r    <= k_b_s;
        s1_xa_r    <= x_a_s;
        s1_xb_r    <= x_b_s;
        s1_exact_r <= exact_s;
      end
    end
  end

  // ---------------- S2: fraction sum + correction ----------------
  logic [F:0]   sum_s;
  logic         carry_s;
  logic [F-1:0] frac_s;
  logic [F:0]   corr_s;
  logic [F:0]   m_s;
  logic [F+1:0] mant_s;
  logic [KW-1:0] k_s;

  // Log-domain add, then the mantissa 1.m with the linear error correction.
  always_comb begin
    sum_s   = {1'b0, s1_xa_r} + {1'b0, s1_xb_r};
    carry_s = sum_s[F];
    frac_s  = sum_s[F-1:0];
    k_s     = KW'(s1_ka_r) + KW'(s1_kb_r) + KW'(carry_s);
    // A zero fraction means both operands were powers of two: keep it exact.
    if (frac_s == '0) begin
      corr_s = '0;
    end else if (carry_s) begin
      corr_s = CORR_HALF;
    end else begin
      corr_s = CORR_FULL;
    end
    m_s    = {1'b0, frac_s} + corr_s;
    // Carry out of m_s lands in bit F+1, giving the {10, m_low} form.
    mant_s = {1'b0, m_s} + {2'b01, {F{1'b0}}};
  end

  logic             s2_valid_r;
  approx_mode_t     s2_mode_r;
  logic [TAG_WIDTH-1:0] s2_tag_r;
  logic             s2_sign_r, s2_zero_r;
  logic [KW-1:0]    s2_k_r;
  logic [F+1:0]     s2_mant_r;
  logic [PW-1:0]    s2_exact_r;

  // S2 register: mantissa and exponent of the approximate product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_r <= 1'b0;
      s2_mode_r  <= MUL_APPROX_U;
      s2_tag_r   <= '0;
      s2_sign_r  <= 1'b0;
      s2_zero_r  <= 1'b0;
      s2_k_r     <= '0;
      s2_mant_r  <= '0;
      s2_exact_r <= '0;
    end else if (adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_mode_r  <= s1_mode_r;
        s2_tag_r   <= s1_tag_r;
        s2_sign_r  <= s1_sign_r;
        s2_zero_r  <= s1_zero_r;
        s2_k_r     <= k_s;
        s2_mant_r  <= mant_s;
        s2_exact_r <= s1_exact_r;
      end
    end
  end

  // ---------------- S3: scale / sign / saturate ----------------
  logic [XW-1:0]   wide_s;
  logic [PW+1:0]   p_s;
  logic [PW+1:0]   lim_s;
  logic [PW+1:0]   sat_mag_s;
  logic [PW-1:0]   result_s;

  // Antilog by shifting, then saturate and apply the sign per mode.
  always_comb begin
    wide_s = XW'(s2_mant_r) << s2_k_r;
    p_s    = (PW + 2)'(wide_s >> F);
    if (s2_sign_r) begin
      lim_s = NEG_LIM;
    end else begin
      lim_s = POS_LIM;
    end
    if (p_s > lim_s) begin
      sat_mag_s = lim_s;
    end else begin
      sat_mag_s = p_s;
    end
    result_s = '0;
    case (s2_mode_r)
      MUL_EXACT: begin
        result_s = s2_exact_r;
      end
      MUL_APPROX_S: begin
        if (s2_zero_r) begin
          result_s = '0;
        end else if (s2_sign_r) begin
          result_s = ~PW'(sat_mag_s) + ONE_P;
        end else begin
          result_s = PW'(sat_mag_s);
        end
      end
      default: begin
        if (s2_zero_r) begin
          result_s = '0;
        end else if (p_s[PW+1:PW] != 2'b00) begin
          result_s = '1;
        end else begin
          result_s = p_s[PW-1:0];
        end
      end
    endcase
  end

  // Output register: holds the result until the consumer takes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_product <= '0;
      out_tag     <= '0;
    end else if (adv_s) begin
      out_valid <= s2_valid_r;
      if (s2_valid_r) begin
        out_product <= result_s;
        out_tag     <= s2_tag_r;
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Self-checking bench for approx_mul_pipe (WIDTH=16, TAG_WIDTH=4).
module tb_approx_mul_pipe;
  import approx_mul_pipe_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  approx_mode_t in_mode;
  logic [15:0]  in_a, in_b;
  logic [3:0]   in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_product;
  logic [3:0]   out_tag;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle        = 0;

  typedef struct packed {
    logic [1:0]  mode;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  tag;
    int          cyc;
  } in_rec_t;

  typedef struct packed {
    logic [31:0] prod;
    logic [3:0]  tag;
    int          cyc;
  } out_rec_t;

  in_rec_t  in_q[$];
  out_rec_t out_q[$];

  approx_mul_pipe #(.WIDTH(16), .TAG_WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mode     (in_mode),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_tag     (out_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Record every accepted input and every drained output, mid-cycle.
  always @(negedge clk) begin
    in_rec_t  ir;
    out_rec_t orr;
    if (reset && in_valid && in_ready) begin
      ir.mode = in_mode; ir.a = in_a; ir.b = in_b; ir.tag = in_tag; ir.cyc = cycle;
      in_q.push_back(ir);
    end
    if (reset && out_valid && out_ready) begin
      orr.prod = out_product; orr.tag = out_tag; orr.cyc = cycle;
      out_q.push_back(orr);
    end
  end

  // Reference: Mitchell product from the arithmetic definition, F = 15.
  localparam longint ONE_F = 64'd32768;
  localparam longint CORR  = 64'd5 * 64'd512;   // 0.078125 * 2^15
  function automatic logic [31:0] ref_mul(input logic [1:0] mode,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
    longint ma, mb, xa, xb, s, frac, m, p, lim;
    int ka, kb, c;
    bit neg;
    ma = longint'(a); mb = longint'(b); neg = 1'b0;
    if (mode == 2'd2) return 32'(ma * mb);
    if (mode == 2'd1) begin
      if (a[15]) ma = 64'd65536 - ma;
      if (b[15]) mb = 64'd65536 - mb;
      neg = a[15] ^ b[15];
    end
    if (ma == 0 || mb == 0) return 32'd0;
    ka = 0; while ((longint'(1) << (ka + 1)) <= ma) ka++;
    kb = 0; while ((longint'(1) << (kb + 1)) <= mb) kb++;
    xa = (ma - (longint'(1) << ka)) * (longint'(1) << (15 - ka));
    xb = (mb - (longint'(1) << kb)) * (longint'(1) << (15 - kb));
    s  = xa + xb;
    c  = (s >= ONE_F) ? 1 : 0;
    frac = (c == 1) ? s - ONE_F : s;
    if (frac != 0) frac = frac + ((c == 1) ? CORR / 2 : CORR);
    m = ONE_F + frac;
    p = (m * (longint'(1) << (ka + kb + c))) / ONE_F;
    if (mode == 2'd1) begin
      lim = neg ? (longint'(1) << 31) : (longint'(1) << 31) - 1;
      if (p > lim) p = lim;
      return neg ? 32'(-p) : 32'(p);
    end
    if (p > 64'hFFFF_FFFF) p = 64'hFFFF_FFFF;
    return 32'(p);
  endfunction

  function automatic logic [15:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0001 << $urandom_range(0, 15);
      4:       return 16'($urandom_range(1, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic cyc_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(input logic [3:0] tag);
    in_mode = approx_mode_t'(2'($urandom_range(0, 2)));
    in_a    = rand_operand();
    in_b    = rand_operand();
    in_tag  = tag;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_mode = MUL_APPROX_U; in_a = 16'd0; in_b = 16'd0; in_tag = 4'd0;
    repeat (3) cyc_step();
    reset = 1'b1;
    cyc_step();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++; if (out_product !== 32'd0) begin tests_failed++; $display("FAIL reset_out_product: got %h expected 0", out_product); end
    tests_run++; if (out_tag !== 4'd0) begin tests_failed++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [1:0]  dm [9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd1, 2'd1};
    logic [15:0] da [9] = '{16'd3, 16'd3, 16'd2, 16'd0, 16'hFFFF, 16'hFFFF, 16'hFFFD, 16'h8000, 16'h8000};
    logic [15:0] db [9] = '{16'd5, 16'd3, 16'd4, 16'hABCD, 16'hFFFF, 16'hFFFF, 16'd5, 16'd1, 16'h8000};
    logic [31:0] de [9] = '{32'd14, 32'd8, 32'd8, 32'd0, 32'hFFFF_FFFF, 32'hFFFE_0001,
                            32'hFFFF_FFF2, 32'hFFFF_8000, 32'h4000_0000};
    int base, ib, w;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      base = out_q.size(); ib = in_q.size();
      in_mode = approx_mode_t'(dm[i]); in_a = da[i]; in_b = db[i]; in_tag = 4'(i);
      in_valid = 1'b1;
      cyc_step();
      in_valid = 1'b0;
      w = 0;
      while (out_q.size() == base && w < 10) begin cyc_step(); w++; end
      tests_run++;
      if (out_q.size() == base || in_q.size() == ib) begin
        tests_failed++;
        $display("FAIL directed_%0d_timeout: got no result expected product %h", i, de[i]);
      end else begin
        if (out_q[base].prod !== de[i]) begin tests_failed++;
          $display("FAIL directed_%0d_product: got %h expected %h", i, out_q[base].prod, de[i]); end
        tests_run++;
        if (out_q[base].tag !== 4'(i)) begin tests_failed++;
          $display("FAIL directed_%0d_tag: got %0d expected %0d", i, out_q[base].tag, i); end
        tests_run++;
        if (out_q[base].cyc - in_q[ib].cyc !== 3) begin tests_failed++;
          $display("FAIL directed_%0d_latency: got %0d expected 3", i, out_q[base].cyc - in_q[ib].cyc); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int base, ib, w;
    logic [31:0] exp_p;
    base = out_q.size(); ib = in_q.size();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_rand(4'(i));
      in_valid = 1'b1;
      cyc_step();
    end
    in_valid = 1'b0;
    w = 0;
    while (out_q.size() < base + 8 && w < 20) begin cyc_step(); w++; end
    tests_run++;
    if (out_q.size() != base + 8 || in_q.size() != ib + 8) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d outputs %0d inputs expected 8", out_q.size() - base, in_q.size() - ib);
    end else begin
      tests_run++;
      if (out_q[base].cyc - in_q[ib].cyc !== 3) begin tests_failed++;
        $display("FAIL b2b_latency: got %0d expected 3", out_q[base].cyc - in_q[ib].cyc); end
      for (int i = 0; i < 8; i++) begin
        exp_p = ref_mul(in_q[ib + i].mode, in_q[ib + i].a, in_q[ib + i].b);
        tests_run++;
        if (out_q[base + i].prod !== exp_p) begin tests_failed++;
          $display("FAIL b2b_product_%0d: got %h expected %h", i, out_q[base + i].prod, exp_p); end
        tests_run++;
        if (out_q[base + i].tag !== 4'(i)) begin tests_failed++;
          $display("FAIL b2b_tag_%0d: got %0d expected %0d", i, out_q[base + i].tag, i); end
        tests_run++;
        if (out_q[base + i].cyc !== out_q[base].cyc + i) begin tests_failed++;
          $display("FAIL b2b_cycle_%0d: got %0d expected %0d", i, out_q[base + i].cyc, out_q[base].cyc + i); end
      end
    end
  endtask

  task automatic test_backpressure();
    int base, ib, w;
    logic [31:0] exp_p;
    logic [3:0]  tg;
    base = out_q.size(); ib = in_q.size();
    out_ready = 1'b0; in_valid = 1'b1; tg = 4'd8;
    w = 0;
    while (out_valid !== 1'b1 && w < 10) begin
      drive_rand(tg); tg = tg + 4'd1;
      cyc_step(); w++;
    end
    tests_run++;
    if (out_valid !== 1'b1 || in_q.size() == ib) begin
      tests_failed++;
      $display("FAIL bp_fill_timeout: got out_valid %b expected 1", out_valid);
    end else begin
      exp_p = ref_mul(in_q[ib].mode, in_q[ib].a, in_q[ib].b);
      for (int s = 0; s < 5; s++) begin
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready_%0d: got %b expected 0", s, in_ready); end
        tests_run++;
        if (out_product !== exp_p) begin tests_failed++; $display("FAIL bp_product_%0d: got %h expected %h", s, out_product, exp_p); end
        tests_run++;
        if (out_tag !== in_q[ib].tag) begin tests_failed++; $display("FAIL bp_tag_%0d: got %0d expected %0d", s, out_tag, in_q[ib].tag); end
        drive_rand(tg); tg = tg + 4'd1;
        cyc_step();
      end
    end
    tests_run++;
    if (in_q.size() - ib !== 3) begin tests_failed++;
      $display("FAIL bp_accepts: got %0d expected 3", in_q.size() - ib); end
    out_ready = 1'b1; in_valid = 1'b0;
    w = 0;
    while (out_q.size() < base + 3 && w < 20) begin cyc_step(); w++; end
    repeat (4) cyc_step();
    tests_run++;
    if (out_q.size() - base !== in_q.size() - ib) begin
      tests_failed++;
      $display("FAIL bp_drain_count: got %0d expected %0d", out_q.size() - base, in_q.size() - ib);
    end else begin
      for (int i = 0; i < out_q.size() - base; i++) begin
        exp_p = ref_mul(in_q[ib + i].mode, in_q[ib + i].a, in_q[ib + i].b);
        tests_run++;
        if (out_q[base + i].prod !== exp_p || out_q[base + i].tag !== in_q[ib + i].tag) begin
          tests_failed++;
          $display("FAIL bp_drain_%0d: got %h/%0d expected %h/%0d", i, out_q[base + i].prod,
                   out_q[base + i].tag, exp_p, in_q[ib + i].tag);
        end
      end
    end
  endtask

  task automatic test_random();
    int base, ib, w;
    logic [31:0] exp_p;
    logic [3:0]  tg;
    base = out_q.size(); ib = in_q.size(); tg = 4'd0;
    for (int i = 0; i < 80; i++) begin
      drive_rand(tg); tg = tg + 4'd1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc_step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    w = 0;
    while (out_q.size() - base < in_q.size() - ib && w < 30) begin cyc_step(); w++; end
    repeat (4) cyc_step();
    tests_run++;
    if (out_q.size() - base !== in_q.size() - ib) begin
      tests_failed++;
      $display("FAIL rand_count: got %0d expected %0d", out_q.size() - base, in_q.size() - ib);
    end else begin
      for (int i = 0; i < out_q.size() - base; i++) begin
        exp_p = ref_mul(in_q[ib + i].mode, in_q[ib + i].a, in_q[ib + i].b);
        tests_run++;
        if (out_q[base + i].prod !== exp_p) begin tests_failed++;
          $display("FAIL rand_product_%0d: mode %0d a %h b %h got %h expected %h", i, in_q[ib + i].mode,
                   in_q[ib + i].a, in_q[ib + i].b, out_q[base + i].prod, exp_p); end
        tests_run++;
        if (out_q[base + i].tag !== in_q[ib + i].tag) begin tests_failed++;
          $display("FAIL rand_tag_%0d: got %0d expected %0d", i, out_q[base + i].tag, in_q[ib + i].tag); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    int base, w;
    base = out_q.size();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_mode = MUL_APPROX_U; in_a = 16'd7 + 16'(i); in_b = 16'd9; in_tag = 4'd12 + 4'(i);
      in_valid = 1'b1;
      cyc_step();
    end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    tests_run++; if (out_product !== 32'd0) begin tests_failed++; $display("FAIL midrst_out_product: got %h expected 0", out_product); end
    tests_run++; if (out_tag !== 4'd0) begin tests_failed++; $display("FAIL midrst_out_tag: got %h expected 0", out_tag); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    repeat (2) cyc_step();
    reset = 1'b1;
    repeat (6) cyc_step();
    tests_run++;
    if (out_q.size() !== base) begin tests_failed++;
      $display("FAIL midrst_stale: got %0d outputs expected 0", out_q.size() - base); end
    base = out_q.size();
    in_mode = MUL_APPROX_U; in_a = 16'd3; in_b = 16'd5; in_tag = 4'd5;
    in_valid = 1'b1;
    cyc_step();
    in_valid = 1'b0;
    w = 0;
    while (out_q.size() == base && w < 10) begin cyc_step(); w++; end
    tests_run++;
    if (out_q.size() == base) begin
      tests_failed++;
      $display("FAIL midrst_after_timeout: got no result expected 14");
    end else if (out_q[base].prod !== 32'd14 || out_q[base].tag !== 4'd5) begin
      tests_failed++;
      $display("FAIL midrst_after: got %h/%0d expected 0000000e/5", out_q[base].prod, out_q[base].tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/approx_mul_pipe.md
# approx_mul_pipe

Parametrised, pipelined Mitchell-logarithm approximate multiplier with linear error correction. It accepts WIDTH-bit operands in unsigned, signed or exact mode and returns a 2*WIDTH-bit integer product after three stages. Transactions use a valid/ready handshake and carry a tag. The block sits beside the integer execute pipeline as the low-power multiply path, and the exact mode lets software select precision per operation.

## Interface
- WIDTH, 16: operand width; minimum 8.
- TAG_WIDTH, 4: width of the opaque tag that travels with each operation.
- clk  in  1  clock; all state is updated on its rising edge.
- reset  in  1  asynchronous reset, active-low. Asserted when 0.
- in_valid  in  1  operation present on the input.
- in_ready  out  1  block accepts the input this cycle.
- in_mode  in  approx_mode_t (2)  MUL_APPROX_U, MUL_APPROX_S, or MUL_EXACT (unsigned exact).
- in_a, in_b  in  WIDTH  operands.
- in_tag  in  TAG_WIDTH  user tag.
- out_valid  out  1  result present on the output.
- out_ready  in  1  consumer accepts the result.
- out_product  out  2*WIDTH  result; two's complement in MUL_APPROX_S.
- out_tag  out  TAG_WIDTH  tag of the result.

## Operation
- F = WIDTH-1 fraction bits. CORR = 5·2^(F-6), which is 0.078125 in F-bit fixed point.
- S1 (sign/normalise):
  - In signed mode, take magnitudes |a| and |b| as WIDTH-bit unsigned values; -2^(WIDTH-1) is legal. Result sign = a_msb XOR b_msb.
  - k = leading-one position. x = (mag << (F-k)) with the leading one dropped, as an F-bit fraction.
  - zero = (mag_a==0 || mag_b==0).
- S2 (fraction sum):
  - s = x_a + x_b, F+1 bits. c = s[F]. K = k_a + k_b + c.
  - m = s[F-1:0] plus correction. The correction is CORR if c=0 and CORR>>1 if c=1. It is applied only when s[F-1:0] != 0, so power-of-two operands produce exact products.
  - Mantissa M = {01, m}. If adding the correction carries out, M = {10, m_low}.
- S3 (scale/sign/saturate):
  - P = floor((M << K) / 2^F), computed in at least 2*WIDTH+2 bits.
  - Unsigned: if P ≥ 2^(2W), output 2^(2W)-1.
  - Signed: saturate the magnitude to 2^(2W-1)-1 for a positive result and 2^(2W-1) for a negative one, then negate if sign=1.
  - zero forces P=0 and a positive sign.
- MUL_EXACT: the S1 register holds a*b, computed exactly and unsigned. S2 and S3 pass it through unchanged.
- The tag and mode travel with the data through every stage.

## Timing
- Three register stages. Latency is 3 cycles from an accepted input (in_valid && in_ready) to out_valid, with out_ready held high.
- Throughput is one operation per cycle.
- Global stall enable: adv = !out_valid || out_ready. in_ready = adv.
  - All stages move only when adv=1. Bubbles are not compressed.
- An out_valid/out_product/out_tag set must hold stable until out_ready=1. Inputs are sampled only when in_valid && in_ready.
- Simultaneous accept and drain in the same cycle is allowed, with no bubble.
- Reset values:
  - All stage valid bits 0.
  - out_valid=0, out_product=0, out_tag=0.
  - in_ready=1 after reset deasserts, since the pipeline is empty.
- Reset asserted mid-operation discards all in-flight results. Data is not retained.

## Structure
- In defines: add typedef enum logic[1:0] approx_mode_t with MUL_APPROX_U=0, MUL_APPROX_S=1, MUL_EXACT=2.
- In defines: add the constant MITCHELL_CORR_NUM=5 and MITCHELL_CORR_SHIFT=6. These define CORR.
- Sub-module leading_one_detector (parameter WIDTH). It outputs the $clog2(WIDTH)-bit index and an is_zero flag. It is instantiated twice in S1.
- All other logic lives in approx_mul_pipe: one always_ff per stage and combinational stage logic.

## Test plan
- WIDTH=16, approx unsigned: 3×5 → 14. 3×3 → 8. 2×4 → 8 (power of two, exact). All return with latency exactly 3.
- Zero and saturation: 0×0xABCD → 0. 0xFFFF×0xFFFF in approx unsigned → 0xFFFF_FFFF (saturated). The same operands in MUL_EXACT → 0xFFFE_0001.
- Signed approx: -3×5 → 0xFFFF_FFF2 (-14). -32768×1 → 0xFFFF_8000. -32768×-32768 → 0x4000_0000.
- Back-to-back: send 8 operations on consecutive cycles with tags 0-7, out_ready=1. Outputs appear on 8 consecutive cycles with tags in order.
- Backpressure: hold out_ready=0 for 5 cycles while in_valid=1.
  - in_ready drops once out_valid=1.
  - out_product and out_tag stay stable.
  - No operation is lost or duplicated after release.
- Reset: assert reset with 3 operations in flight. All outputs go to 0 immediately, asynchronously. After release, no stale out_valid appears and a new 3×5 returns 14.
